// File: rtl/gamepad_pkg.sv
// Shared types and constants for the serial gamepad device.
package gamepad_pkg;
  localparam int          GP_NBITS        = 16;
  localparam logic [15:0] GP_BTN_RELEASED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SHIFT
  } gp_state_e;
endpackage

// File: rtl/gamepad_if.sv
// Host-facing pad pins plus local button/status signals of the gamepad device.
interface gamepad_if;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_data;
  logic [15:0] btn;
  logic        btn_load;
  logic        busy;
  logic        frame_done;
  logic        abort;

  modport master (
    output pad_latch, pad_clk, btn, btn_load,
    input  pad_data, busy, frame_done, abort
  );

  modport slave (
    input  pad_latch, pad_clk, btn, btn_load,
    output pad_data, busy, frame_done, abort
  );
endinterface

// File: rtl/gamepad_in_filter.sv
// Two-flop synchronizer, FILT_LEN-sample level filter and registered edge pulses
// for one asynchronous pad input.
module gp_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);
  logic       s1_q, s2_q;
  logic       filt_q, filt_d;
  logic       filt_dly_q;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic [3:0] cnt_q, cnt_d;

  // cnt counts consecutive samples disagreeing with the accepted level
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (s2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == 4'(FILT_LEN - 1)) begin
      filt_d = s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    rise_d = filt_q & ~filt_dly_q;
    fall_d = ~filt_q & filt_dly_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= pin;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/gamepad_device.sv
// Serial gamepad: latches a staged 16-bit button word on the host latch and
// shifts it out bit0-first on filtered host shift clocks.
module gamepad_device
  import gamepad_pkg::*;
#(
  parameter int   FILT_LEN = 3,
  parameter logic FILL     = 1'b0
) (
  input logic      clk,
  input logic      rst,
  gamepad_if.slave pad
);
  logic latch_rise, latch_fall, clk_rise, unused_clk_fall;

  gp_in_filter #(.FILT_LEN(FILT_LEN)) u_latch_filt (
    .clk (clk), .rst (rst), .pin (pad.pad_latch),
    .rise(latch_rise), .fall(latch_fall)
  );

  gp_in_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk (clk), .rst (rst), .pin (pad.pad_clk),
    .rise(clk_rise), .fall(unused_clk_fall)
  );

  gp_state_e            state_q, state_d;
  logic [GP_NBITS-1:0]  stage_q, stage_d;
  logic [GP_NBITS-1:0]  shreg_q, shreg_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 pad_data_q, pad_data_d;
  logic                 frame_done_q, frame_done_d;
  logic                 abort_q, abort_d;

  always_comb begin
    stage_d      = pad.btn_load ? pad.btn : stage_q;
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      ST_IDLE: if (latch_rise) state_d = ST_LATCH;
      ST_LATCH: begin
        // stage_d includes a same-cycle btn_load, giving the bypass for free
        shreg_d = stage_d;
        if (latch_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // latch edges take priority; a coincident clock rise is dropped
        if (latch_rise) begin
          state_d = ST_LATCH;
          abort_d = 1'b1;
        end else if (clk_rise) begin
          shreg_d = {FILL, shreg_q[GP_NBITS-1:1]};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(GP_NBITS - 1)) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_LATCH: pad_data_d = stage_d[0];
      ST_SHIFT: pad_data_d = shreg_d[0];
      default:  pad_data_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stage_q      <= GP_BTN_RELEASED;
      shreg_q      <= GP_BTN_RELEASED;
      cnt_q        <= '0;
      pad_data_q   <= FILL;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      pad_data_q   <= pad_data_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
    end
  end

  assign pad.pad_data   = pad_data_q;
  assign pad.busy       = (state_q != ST_IDLE);
  assign pad.frame_done = frame_done_q;
  assign pad.abort      = abort_q;
endmodule

// File: tb/tb_gamepad_device.sv
// Directed and randomized frames checked against a word/position model of the
// host-visible serial protocol.
module tb_gamepad_device;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gamepad_if pad ();
  gamepad_device #(.FILT_LEN(3), .FILL(1'b0)) dut (.clk(clk), .rst(rst), .pad(pad));

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int ab_cnt = 0;

  logic [15:0] exp_word;
  int          exp_pos;

  always @(negedge clk) begin
    if (pad.frame_done === 1'b1) fd_cnt++;
    if (pad.abort === 1'b1) ab_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_btn(input logic [15:0] w);
    pad.btn = w; pad.btn_load = 1'b1;
    step(1);
    pad.btn_load = 1'b0;
  endtask

  task automatic latch_pulse(input int hi);
    pad.pad_latch = 1'b1;
    step(hi);
    pad.pad_latch = 1'b0;
  endtask

  // Host reads pad_data at the end of each low phase, then raises pad_clk.
  task automatic shift(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      step(lo);
      chk($sformatf("bit%0d", exp_pos), 32'(pad.pad_data), 32'(exp_word[exp_pos]));
      exp_pos++;
      pad.pad_clk = 1'b1;
      step(hi);
      pad.pad_clk = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [15:0] w);
    exp_word = w;
    exp_pos  = 0;
    latch_pulse(10);
  endtask

  task automatic end_frame(input string tag, input int fd_before);
    step(8);
    chk({tag, "_fd"}, 32'(fd_cnt), 32'(fd_before + 1));
    chk({tag, "_idle"}, {30'd0, pad.busy, pad.pad_data}, 32'd0);
  endtask

  int fd0, ab0;
  logic [15:0] w;

  initial begin
    pad.pad_latch = 1'b0; pad.pad_clk = 1'b0; pad.btn = '0; pad.btn_load = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_pad_data", 32'(pad.pad_data), 32'd0);
    chk("rst_busy", 32'(pad.busy), 32'd0);
    chk("rst_frame_done", 32'(pad.frame_done), 32'd0);
    chk("rst_abort", 32'(pad.abort), 32'd0);

    // Latch-to-pad_data latency: staging is all released, so bit0 is 1
    pad.pad_latch = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("lat_k5", 32'(pad.pad_data), 32'd0);
    @(posedge clk);
    #1 chk("lat_k6", 32'(pad.pad_data), 32'd1);
    chk("lat_busy", 32'(pad.busy), 32'd1);
    @(negedge clk);
    step(4);
    pad.pad_latch = 1'b0;
    exp_word = 16'hFFFF; exp_pos = 0;
    fd0 = fd_cnt;
    shift(16, 8, 8);
    end_frame("post_rst", fd0);

    // Basic frame with known word
    load_btn(16'hA5F0);
    fd0 = fd_cnt;
    start_frame(16'hA5F0);
    shift(16, 8, 8);
    end_frame("a5f0", fd0);

    // Short glitches on pad_clk must not shift
    w = 16'($urandom);
    load_btn(w);
    fd0 = fd_cnt;
    start_frame(w);
    shift(4, 8, 8);
    step(4);
    pad.pad_clk = 1'b1; step(1); pad.pad_clk = 1'b0; step(6);
    pad.pad_clk = 1'b1; step(2); pad.pad_clk = 1'b0;
    shift(12, 8, 8);
    end_frame("glitch", fd0);

    // Abort after 7 clocks, then a full frame
    w = 16'($urandom);
    load_btn(w);
    fd0 = fd_cnt; ab0 = ab_cnt;
    start_frame(w);
    shift(7, 6, 9);
    chk("pre_abort", 32'(ab_cnt), 32'(ab0));
    step(8);
    start_frame(w);
    chk("abort_pulse", 32'(ab_cnt), 32'(ab0 + 1));
    chk("abort_no_fd", 32'(fd_cnt), 32'(fd0));
    shift(15, 6, 9);
    step(8);
    chk("abort_fd_15", 32'(fd_cnt), 32'(fd0));
    shift(1, 6, 9);
    end_frame("abort", fd0);
    chk("abort_once", 32'(ab_cnt), 32'(ab0 + 1));

    // btn_load coinciding with the filtered latch rise is used for the frame
    load_btn(16'hBEEF);
    fd0 = fd_cnt;
    pad.pad_latch = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    pad.btn = 16'h0001; pad.btn_load = 1'b1;
    step(1);
    pad.btn_load = 1'b0;
    step(5);
    pad.pad_latch = 1'b0;
    exp_word = 16'h0001; exp_pos = 0;
    shift(8, 8, 8);
    load_btn(16'h1234);
    shift(8, 8, 8);
    end_frame("bypass", fd0);

    // Reset mid-frame abandons it silently; staging returns to released
    w = 16'($urandom);
    load_btn(w);
    start_frame(w);
    shift(5, 8, 8);
    fd0 = fd_cnt; ab0 = ab_cnt;
    rst = 1'b1; step(2); rst = 1'b0;
    step(1);
    chk("mid_rst_pad_data", 32'(pad.pad_data), 32'd0);
    chk("mid_rst_busy", 32'(pad.busy), 32'd0);
    step(10);
    chk("mid_rst_pulses", 32'(fd_cnt + ab_cnt), 32'(fd0 + ab0));
    start_frame(16'hFFFF);
    shift(16, 8, 8);
    end_frame("after_rst", fd0);

    // Randomized frames with random host timing
    for (int f = 0; f < 4; f++) begin
      w = 16'($urandom);
      load_btn(w);
      fd0 = fd_cnt;
      start_frame(w);
      shift(16, int'($urandom_range(4, 8)), int'($urandom_range(8, 12)));
      end_frame($sformatf("rand%0d", f), fd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gamepad_device.md
GAMEPAD_DEVICE -- requirements
Module: gamepad_device

Interface
REQ-001 SHALL have parameter FILT_LEN, default 3: consecutive equal synchronized samples required before a pad input level is accepted (range 1..15).
REQ-002 SHALL have parameter FILL, default 1'b0: level driven on pad_data when no frame bit is being presented.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pad_latch  input  1  latch from console/host, asynchronous to clk.
REQ-006 pad_clk  input  1  shift clock from console/host, asynchronous to clk, idles low.
REQ-007 pad_data  output  1  registered serial button data to host.
REQ-008 btn  input  16  wire-level button word: bit0 shifts first; 0 = pressed.
REQ-009 btn_load  input  1  one-cycle strobe: copy btn into staging register.
REQ-010 busy  output  1  high in states LATCH and SHIFT.
REQ-011 frame_done  output  1  one-cycle pulse after the 16th shift clock.
REQ-012 abort  output  1  one-cycle pulse when a latch rise interrupts an incomplete SHIFT.

Function
REQ-013 Each pad input SHALL pass through a 2-flop synchronizer, then a filter whose output changes only after FILT_LEN consecutive synchronized samples of the new level.
REQ-014 Rising/falling edges SHALL be detected on filtered signals only; pad_data SHALL update exactly FILT_LEN+3 clk cycles after the first clk edge sampling the new pin level.
REQ-015 Staging register SHALL load btn on any cycle with btn_load=1, independent of state.
REQ-016 States: IDLE, LATCH, SHIFT.
REQ-017 IDLE: pad_data=FILL; filtered pad_clk edges ignored; filtered latch rise -> LATCH.
REQ-018 LATCH: shift register reloads from staging every cycle; pad_data=staging[0]; if btn_load coincides, new btn value used that same cycle (bypass); filtered latch fall -> SHIFT with bit counter=0, shift register frozen.
REQ-019 SHIFT: pad_data=shreg[0]; each filtered pad_clk rise shifts right, inserting FILL at bit15, counter+1.
REQ-020 On the pad_clk rise that brings counter to 16: frame_done=1 for one cycle, next state IDLE, pad_data=FILL.
REQ-021 Filtered latch rise in SHIFT -> LATCH and abort=1 for one cycle; latch rise in LATCH/IDLE raises no abort.
REQ-022 Latch edge and pad_clk rise in the same cycle: latch edge wins, clock edge discarded.
REQ-023 Counter SHALL be 5 bits, never exceed 16, never wrap.
REQ-024 Latch held high indefinitely SHALL keep the block in LATCH with no pulses.

Reset
REQ-025 On rst: state IDLE, counter 0, staging 16'hFFFF, shreg 16'hFFFF, pad_data=FILL, busy/frame_done/abort=0, synchronizers and filters cleared to 0.
REQ-026 rst mid-frame SHALL abandon the frame without frame_done or abort; first post-reset latch rise starts a normal frame.

Structure
REQ-027 Package gamepad_pkg SHALL hold the state enum, GP_NBITS=16, GP_BTN_RELEASED=16'hFFFF.
REQ-028 Sub-module gp_in_filter (synchronizer + FILT_LEN filter + rise/fall pulses) SHALL be instantiated once each for pad_latch and pad_clk.

Verification
REQ-029 btn_load with btn=16'hA5F0; latch pulse 10 clk; 16 clk pulses of 8 clk high/8 low -> sampled sequence 0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1 bit0 first; one frame_done; then pad_data=0.
REQ-030 1-cycle and 2-cycle glitches on pad_clk during SHIFT (FILT_LEN=3) -> no shift, counter unchanged.
REQ-031 Latch rise after 7 shift clocks -> abort pulse; next full frame returns complete staged word, frame_done only at its end.
REQ-032 btn_load 16'h0001 in the same cycle as filtered latch rise -> frame presents 16'h0001; later btn_load during SHIFT does not alter the in-flight frame.
REQ-033 rst asserted after 5 shift clocks -> pad_data=0, busy=0, no pulses; next frame returns 16'hFFFF.
REQ-034 pad_latch pin edge at clk edge k -> pad_data changes at clk edge k+6 (FILT_LEN=3).
